// File: rtl/srt_div_sched_pkg.sv
// Shared widths, FSM state encoding and the leading-zero helper for the
// two-requester SRT radix-2 divider scheduler.
package srt_pkg;

    localparam int N_REQ = 2;
    localparam int W     = 8;
    localparam int LZW   = $clog2(W);
    localparam int CNTW  = $clog2(W);

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        ITER,
        FIX,
        DONE
    } state_e;

    // Highest set bit wins; a zero divisor yields 0 and is handled separately.
    function automatic logic [LZW-1:0] lzCount(input logic [W-1:0] v);
        logic [LZW-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) n = LZW'(W - 1 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/srt_div_sched_if.sv
// Request/response bundle between the requesters and the shared divider.
interface srt_div_sched_if;
    import srt_pkg::*;

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_dividend;
    logic [N_REQ*W-1:0] req_divisor;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [W-1:0]       rsp_quotient;
    logic [W:0]         rsp_remainder;
    logic               rsp_dbz;

    modport master (
        output req_valid, req_dividend, req_divisor, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz
    );

endinterface

// File: rtl/srt_div_sched_step.sv
// One SRT radix-2 step on the {P,A} register: decode the top three bits of P,
// shift, and add or subtract the normalised divisor.
module srt_div_step
    import srt_pkg::*;
(
    input  logic [2*W:0] pa_i,
    input  logic [W:0]   b_i,
    output logic [2*W:0] pa_o,
    output logic         qPos_o,
    output logic         qNeg_o
);

    logic [2*W:0] shifted;
    logic [W:0]   pHi;

    // P stays in [-B, B), so modulo-2^(W+1) add/sub after the shift is exact.
    always_comb begin
        shifted = pa_i << 1;
        pHi     = shifted[2*W:W];
        pa_o    = shifted;
        qPos_o  = 1'b0;
        qNeg_o  = 1'b0;
        if (pa_i[2*W:2*W-2] == 3'b000 || pa_i[2*W:2*W-2] == 3'b111) begin
            pa_o = shifted;
        end else if (pa_i[2*W]) begin
            pa_o   = {pHi + b_i, shifted[W-1:0]};
            qNeg_o = 1'b1;
        end else begin
            pa_o   = {pHi - b_i, shifted[W-1:0]};
            qPos_o = 1'b1;
        end
    end

endmodule

// File: rtl/srt_div_sched.sv
// Round-robin scheduler in front of one multi-cycle SRT radix-2 divider
// shared by two requesters; one operation in flight at a time.
module srt_div_sched #(
    parameter int N_REQ = srt_pkg::N_REQ,
    parameter int W     = srt_pkg::W
) (
    input  logic            clk,
    input  logic            rst_n,
    srt_div_sched_if.slave  bus
);
    import srt_pkg::*;

    state_e          state_q;
    logic            lastGrant_q;
    logic            rspId_q;
    logic [W:0]      b_q;
    logic [2*W:0]    pa_q;
    logic [W-1:0]    qPos_q;
    logic [W-1:0]    qNeg_q;
    logic [LZW-1:0]  lz_q;
    logic [CNTW-1:0] cnt_q;
    logic            rspValid_q;
    logic            rspDbz_q;
    logic [W-1:0]    rspQuot_q;
    logic [W:0]      rspRem_q;

    logic [N_REQ-1:0] grant;
    logic [W-1:0]     dvdSel;
    logic [W-1:0]     dvsSel;
    logic [LZW-1:0]   lzDiv;
    logic [2*W:0]     paStep;
    logic             stepPos;
    logic             stepNeg;
    logic [W-1:0]     qFix;
    logic [W:0]       pFix;
    logic [W:0]       remFix;

    // Requester 0 wins ties unless it was the last one served.
    always_comb begin
        grant = '0;
        if (state_q == IDLE && rst_n) begin
            if (bus.req_valid[0] && (!bus.req_valid[1] || lastGrant_q)) begin
                grant[0] = 1'b1;
            end else if (bus.req_valid[1]) begin
                grant[1] = 1'b1;
            end
        end
    end

    assign dvdSel = grant[1] ? bus.req_dividend[W +: W] : bus.req_dividend[0 +: W];
    assign dvsSel = grant[1] ? bus.req_divisor[W +: W]  : bus.req_divisor[0 +: W];
    assign lzDiv  = lzCount(b_q[W-1:0]);

    srt_div_step u_step (
        .pa_i   (pa_q),
        .b_i    (b_q),
        .pa_o   (paStep),
        .qPos_o (stepPos),
        .qNeg_o (stepNeg)
    );

    // A negative final remainder means the signed-digit quotient overshot by one.
    always_comb begin
        qFix = qPos_q - qNeg_q;
        pFix = pa_q[2*W:W];
        if (pFix[W]) begin
            pFix = pFix + b_q;
            qFix = qFix - 1'b1;
        end
        remFix = pFix >> lz_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            rspId_q     <= 1'b0;
            b_q         <= '0;
            pa_q        <= '0;
            qPos_q      <= '0;
            qNeg_q      <= '0;
            lz_q        <= '0;
            cnt_q       <= '0;
            rspValid_q  <= 1'b0;
            rspDbz_q    <= 1'b0;
            rspQuot_q   <= '0;
            rspRem_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|grant) begin
                        rspId_q     <= grant[1];
                        lastGrant_q <= grant[1];
                        b_q         <= {1'b0, dvsSel};
                        pa_q        <= {{(W+1){1'b0}}, dvdSel};
                        qPos_q      <= '0;
                        qNeg_q      <= '0;
                        cnt_q       <= '0;
                        state_q     <= NORM;
                    end
                end
                NORM: begin
                    if (b_q == '0) begin
                        rspQuot_q <= '1;
                        rspRem_q  <= {1'b0, pa_q[W-1:0]};
                        rspDbz_q  <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        b_q     <= b_q << lzDiv;
                        pa_q    <= pa_q << lzDiv;
                        lz_q    <= lzDiv;
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    pa_q   <= paStep;
                    qPos_q <= {qPos_q[W-2:0], stepPos};
                    qNeg_q <= {qNeg_q[W-2:0], stepNeg};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNTW'(W - 1)) state_q <= FIX;
                end
                FIX: begin
                    rspQuot_q <= qFix;
                    rspRem_q  <= remFix;
                    rspDbz_q  <= 1'b0;
                    state_q   <= DONE;
                end
                DONE: begin
                    if (!rspValid_q) begin
                        rspValid_q <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rspValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = grant;
    assign bus.rsp_valid     = rspValid_q;
    assign bus.rsp_id        = rspId_q;
    assign bus.rsp_quotient  = rspQuot_q;
    assign bus.rsp_remainder = rspRem_q;
    assign bus.rsp_dbz       = rspDbz_q;

endmodule

// File: tb/tb_srt_div_sched.sv
// Directed-vector bench for srt_div_sched: table of divisions plus hand-built
// sequences for arbitration, back-pressure and mid-operation reset.
module tb_srt_div_sched;
    import srt_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    srt_div_sched_if bus ();

    srt_div_sched #(.N_REQ(N_REQ), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic       id;
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [8:0] r;
        logic       dbz;
        int         lat;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Raise a request, wait (bounded) for its ready, let the accept edge pass.
    task automatic applyStimulus(input logic id, input logic [7:0] dvd, input logic [7:0] dvs);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        if (id) begin
            bus.req_dividend[15:8] = dvd;
            bus.req_divisor[15:8]  = dvs;
        end else begin
            bus.req_dividend[7:0] = dvd;
            bus.req_divisor[7:0]  = dvs;
        end
        bus.req_valid[id] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.req_ready[id]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1 bus.req_valid[id] = 1'b0;
        checkOutput("accept", 32'(ok), 32'd1);
    endtask

    task automatic waitResponse(input int maxEdges, output int lat);
        lat = -1;
        for (int k = 1; k <= maxEdges; k++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic finishResponse(input string tag);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        checkOutput({tag, " rsp_valid drop"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic checkResult(input string tag, input vec_t v, input int lat);
        checkOutput({tag, " latency"}, 32'(lat), 32'(v.lat));
        checkOutput({tag, " id"}, 32'(bus.rsp_id), 32'(v.id));
        checkOutput({tag, " quotient"}, 32'(bus.rsp_quotient), 32'(v.q));
        checkOutput({tag, " remainder"}, 32'(bus.rsp_remainder), 32'(v.r));
        checkOutput({tag, " dbz"}, 32'(bus.rsp_dbz), 32'(v.dbz));
    endtask

    task automatic runVector(input string tag, input vec_t v);
        int lat;
        applyStimulus(v.id, v.dvd, v.dvs);
        waitResponse(30, lat);
        checkResult(tag, v, lat);
        finishResponse(tag);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int   lat;
        bit   stable;
        vec_t v;

        vecs[0] = '{1'b0, 8'd100, 8'd7,   8'd14,  9'd2,  1'b0, 11};
        vecs[1] = '{1'b1, 8'd255, 8'd1,   8'd255, 9'd0,  1'b0, 11};
        vecs[2] = '{1'b1, 8'd7,   8'd9,   8'd0,   9'd7,  1'b0, 11};
        vecs[3] = '{1'b0, 8'd42,  8'd0,   8'hFF,  9'd42, 1'b1, 2};
        vecs[4] = '{1'b0, 8'd200, 8'd13,  8'd15,  9'd5,  1'b0, 11};
        vecs[5] = '{1'b1, 8'd128, 8'd128, 8'd1,   9'd0,  1'b0, 11};
        vecs[6] = '{1'b0, 8'd0,   8'd5,   8'd0,   9'd0,  1'b0, 11};
        vecs[7] = '{1'b1, 8'd255, 8'd255, 8'd1,   9'd0,  1'b0, 11};
        vecs[8] = '{1'b0, 8'd1,   8'd255, 8'd0,   9'd1,  1'b0, 11};
        vecs[9] = '{1'b1, 8'd254, 8'd3,   8'd84,  9'd2,  1'b0, 11};

        rst_n            = 1'b0;
        bus.rsp_ready    = 1'b0;
        bus.req_dividend = {8'd9, 8'd50};
        bus.req_divisor  = {8'd4, 8'd5};
        bus.req_valid    = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset rsp_id", 32'(bus.rsp_id), 32'd0);
        checkOutput("reset quotient", 32'(bus.rsp_quotient), 32'd0);
        checkOutput("reset remainder", 32'(bus.rsp_remainder), 32'd0);
        checkOutput("reset dbz", 32'(bus.rsp_dbz), 32'd0);

        // Both requesters valid out of reset: 0 first, then 1, then 0 again.
        rst_n = 1'b1;
        #1;
        checkOutput("rr first grant", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("busy req_ready", 32'(bus.req_ready), 32'd0);
        waitResponse(30, lat);
        v = '{1'b0, 8'd50, 8'd5, 8'd10, 9'd0, 1'b0, 11};
        checkResult("both id0", v, lat);
        bus.req_valid[0] = 1'b1;
        finishResponse("both id0");
        checkOutput("rr second grant", 32'(bus.req_ready), 32'd2);
        @(posedge clk);
        #1 bus.req_valid[1] = 1'b0;
        waitResponse(30, lat);
        v = '{1'b1, 8'd9, 8'd4, 8'd2, 9'd1, 1'b0, 11};
        checkResult("both id1", v, lat);
        finishResponse("both id1");
        checkOutput("rr third grant", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 2'b00;

        for (int i = 0; i < 10; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        // Consumer stalls in DONE: outputs frozen, no new request admitted.
        applyStimulus(1'b0, 8'd200, 8'd13);
        waitResponse(30, lat);
        checkOutput("stall latency", 32'(lat), 32'd11);
        bus.req_valid = 2'b11;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            stable = bus.rsp_valid && bus.rsp_quotient == 8'd15 && bus.rsp_remainder == 9'd5
                     && bus.rsp_id == 1'b0 && !bus.rsp_dbz && bus.req_ready == 2'b00;
            checkOutput($sformatf("stall cycle %0d", c), 32'(stable), 32'd1);
        end
        bus.req_valid = 2'b00;
        finishResponse("stall");

        // Reset pulsed during the fourth ITER cycle abandons the operation.
        applyStimulus(1'b0, 8'd100, 8'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        stable = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) stable = 1'b0;
        end
        checkOutput("midreset no response", 32'(stable), 32'd1);
        runVector("reissue", vecs[0]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/srt_div_sched.md
SRT_DIV_SCHED -- requirements
Module: srt_div_sched

Interface
REQ-001 Parameter: N_REQ, 2, number of requesters sharing one divider (only 2 is supported).
REQ-002 Parameter: W, 8, dividend/divisor/quotient width; remainder width is W+1.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  N_REQ  per-requester request strobe.
REQ-006 req_ready  out  N_REQ  per-requester accept; one-hot or zero.
REQ-007 req_dividend  in  N_REQ*W  packed dividends, requester i at [i*W +: W].
REQ-008 req_divisor  in  N_REQ*W  packed divisors, same packing.
REQ-009 rsp_valid  out  1  result available.
REQ-010 rsp_ready  in  1  consumer accepts the result.
REQ-011 rsp_id  out  1  index of the requester that owns the result.
REQ-012 rsp_quotient  out  W  unsigned quotient.
REQ-013 rsp_remainder  out  W+1  unsigned remainder; MSB is 0 for every legal result.
REQ-014 rsp_dbz  out  1  divide-by-zero flag.

Function
REQ-015 The FSM SHALL have states IDLE, NORM, ITER, FIX and DONE.
REQ-016 In IDLE, req_ready SHALL be high only for the arbitration winner whose req_valid is high; a request is accepted on the edge where req_valid[i] and req_ready[i] are both high.
REQ-017 Arbitration SHALL be round-robin: when both requesters are valid, the one not granted last wins; a lone valid requester always wins.
REQ-018 Acceptance SHALL latch the operands and the id, then go IDLE->NORM.
REQ-019 NORM (1 cycle) SHALL count the divisor's leading zeros (0..7) and left-shift the divisor and the {P,A} register by that count; if divisor==0 it SHALL go directly to DONE.
REQ-020 ITER SHALL run exactly W cycles with a 0..W-1 counter; each cycle performs one SRT radix-2 step on the top 3 bits of P: equal -> shift, q=0; P negative -> shift, q=-1, P+=B; P positive -> shift, q=+1, P-=B.
REQ-021 FIX (1 cycle) SHALL form the quotient as Qpos-Qneg; if P is negative it SHALL add B to P and subtract 1 from the quotient; it SHALL then right-shift P by the leading-zero count.
REQ-022 DONE SHALL hold rsp_valid high with stable rsp_* outputs until rsp_valid and rsp_ready are both high, then return to IDLE on that edge.
REQ-023 Latency: rsp_valid SHALL first be high 11 edges after the accept edge (NORM 1 + ITER 8 + FIX 1 + DONE entry), or 2 edges after it for divide-by-zero.
REQ-024 Results SHALL be quotient=floor(dividend/divisor) and remainder=dividend mod divisor.
REQ-025 Divide-by-zero SHALL return quotient={W{1}}, remainder={1'b0,dividend} and rsp_dbz=1.
REQ-026 No new request SHALL be accepted in any state other than IDLE (no overlap); the DONE->IDLE return edge SHALL NOT also accept a request.
REQ-027 Arithmetic SHALL use a 2W+1-bit two's-complement {P,A} register; B SHALL be zero-extended to W+1 bits before use.

Reset
REQ-028 With rst_n low at a rising edge: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_remainder=0, rsp_dbz=0, iteration counter=0, last_grant=1 (so requester 0 wins first).
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no response; the requester must re-issue it.

Structure
REQ-030 A shared package srt_pkg SHALL hold the state enum, W, N_REQ and the leading-zero-count width.
REQ-031 The single-step datapath (top-3-bit decode, shift, add/sub) SHALL be a combinational sub-module srt_div_step, instantiated once.

Verification
REQ-032 Requester 0 sends 100/7 -> after 11 edges rsp_valid=1, id=0, q=14, r=2, dbz=0.
REQ-033 Requester 1 sends 255/1 -> q=255, r=0; then 7/9 -> q=0, r=7.
REQ-034 Both requesters valid from reset (0: 50/5, 1: 9/4) -> id 0 served first (q=10, r=0), then id 1 (q=2, r=1).
REQ-035 Requester 0 sends 42/0 -> rsp_valid 2 edges after accept, q=8'hFF, r=42, dbz=1.
REQ-036 rsp_ready held low 20 cycles in DONE -> outputs stable and req_ready=0 throughout.
REQ-037 rst_n pulsed low in the 4th ITER cycle -> next cycle IDLE, rsp_valid=0; a re-issued 100/7 completes correctly.
